btn_debouncer: RTL and testbench

Conditions the raw active-low push buttons (decrement and load/reset) before they reach the countdown stage. Each channel is synchronized to `clk`, debounced by a stable-sample counter, and converted into a clean debounced level plus single-cycle press and release pulses. The countdown stage runs on `clk` and consumes `btn_press` instead of raw button edges.

---
 rtl/btn_debouncer.sv | 200 ++++++++++++++++++++
 tb/tb_btn_debouncer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
// ---------------------------------------------------------------------------
// btn_debouncer
//
// Conditions raw active-low push buttons for the countdown stage. Each channel
// is synchronized to clk, debounced by a stable-sample counter, and turned into
// a clean level plus single-cycle press/release pulses. Channel 0 is decrement,
// channel 1 is load.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   Defined   : a held button emits extra btn_press pulses, the first one
//               REPEAT_DELAY_CYC cycles after the press pulse, then one every
//               REPEAT_RATE_CYC cycles.
//   Undefined : exactly one btn_press per debounced press; REPEAT_* ignored.
//
// Parameters
//   N_BTN            number of independent channels
//   DEBOUNCE_CYC     consecutive stable synchronized samples required (>= 2)
//   REPEAT_DELAY_CYC hold time before the first auto-repeat pulse
//   REPEAT_RATE_CYC  period between subsequent auto-repeat pulses
//
// Ports
//   clk          system clock, all outputs registered on its rising edge
//   rst          asynchronous, active-high reset
//   btn_n        raw bouncing button lines, 0 = pressed
//   btn_level    debounced state, 1 = pressed
//   btn_press    one-cycle pulse per debounced press (and per repeat)
//   btn_release  one-cycle pulse per debounced release
// ---------------------------------------------------------------------------
module btn_debouncer #(
  parameter int N_BTN            = 2,
  parameter int DEBOUNCE_CYC     = 500000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
  // The sample that moves the FSM into a WAIT state is the first stable one,
  // so the WAIT state completes on counter value DEBOUNCE_CYC-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_e;

  // Elaboration-time guard on parameter values.
  if (DEBOUNCE_CYC < 2 || REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_param
    $error("btn_debouncer: DEBOUNCE_CYC must be >= 2 and REPEAT_* >= 1");
  end

  // -------------------------------------------------------------------------
  // Two-stage synchronizer, released (1) out of reset.
  // -------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel debounce FSM.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    assign s = sync2_q[i];

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                             REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE_CYC - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;  // waiting for the first repeat
`endif

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a latch behind.
      state_d   = state_q;
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;  // saturating
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (!s) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (s) begin
            state_d = ST_IDLE;             // bounce rejected
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (s) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!s) begin
            state_d = ST_PRESSED;          // release glitch, level stays 1
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

`ifdef BTN_AUTOREPEAT_EN
      rpt_d       = rpt_q;
      rpt_first_d = rpt_first_q;
      if (state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) begin
        if (rpt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_RATE_LAST)) begin
          rpt_d       = '0;
          rpt_first_d = 1'b0;
          // A release pulse in the same cycle wins; press and release must
          // never coincide on one channel.
          if (!release_d) press_d = 1'b1;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end else begin
        rpt_d       = '0;
        rpt_first_d = 1'b1;
      end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q     <= ST_IDLE;
        cnt_q       <= '0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_q       <= '0;
        rpt_first_q <= 1'b1;
`endif
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
`ifdef BTN_AUTOREPEAT_EN
        rpt_q       <= rpt_d;
        rpt_first_q <= rpt_first_d;
`endif
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// ---------------------------------------------------------------------------
// tb_btn_debouncer
//
// Directed bench for btn_debouncer with DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10,
// REPEAT_RATE_CYC=3. Expected edge numbers are hand-computed: a stable input
// change first sampled on edge 1 produces its pulse right after edge 6.
// Expectations for the auto-repeat scenario follow BTN_AUTOREPEAT_EN.
// ---------------------------------------------------------------------------
module tb_btn_debouncer;

  localparam int N_BTN = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] btn_n = 2'b10;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  btn_debouncer #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYC    (4),
    .REPEAT_DELAY_CYC(10),
    .REPEAT_RATE_CYC (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int press_cnt   [N_BTN];
  int release_cnt [N_BTN];
  int first_press [N_BTN];
  int first_rel   [N_BTN];
  int overlap;
  int press_edges [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < N_BTN; c++) begin
      press_cnt[c]   = 0;
      release_cnt[c] = 0;
      first_press[c] = 0;
      first_rel[c]   = 0;
    end
    press_edges.delete();
  endtask

  // Advance one rising edge, then sample outputs 1 time unit later.
  task automatic tick(input int e);
    @(posedge clk);
    #1;
    for (int c = 0; c < N_BTN; c++) begin
      if (btn_press[c]) begin
        press_cnt[c]++;
        if (first_press[c] == 0) first_press[c] = e;
      end
      if (btn_release[c]) begin
        release_cnt[c]++;
        if (first_rel[c] == 0) first_rel[c] = e;
      end
    end
    if (|(btn_press & btn_release)) overlap++;
    if (btn_press[0]) press_edges.push_back(e);
  endtask

  initial begin
    int exp_edges [$];
    int e;
    logic [N_BTN-1:0] lvl_min;
    overlap = 0;
    clear_stats();

    // ---- Reset with channel 0 already held ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_level",   32'(btn_level),   32'h0);
    check("rst_press",   32'(btn_press),   32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) tick(k);
    check("rst_no_early_press", 32'(press_cnt[0]), 32'd0);
    tick(6);
    check("rst_press_edge6", 32'(btn_press), 32'b01);
    check("rst_level_edge6", 32'(btn_level), 32'b01);
    tick(7);
    check("rst_press_len1", 32'(btn_press), 32'b00);

    // ---- Release after reset press ----
    btn_n = 2'b11;
    clear_stats();
    for (int k = 1; k <= 10; k++) tick(k);
    check("rel0_first_edge", 32'(first_rel[0]), 32'd6);
    check("rel0_count",      32'(release_cnt[0]), 32'd1);
    check("rel0_level",      32'(btn_level), 32'b00);

    // ---- Clean press, held 20 cycles ----
    btn_n = 2'b10;
    clear_stats();
    for (int k = 1; k <= 5; k++) tick(k);
    check("clean_level_edge5", 32'(btn_level[0]), 32'd0);
    tick(6);
    check("clean_press_edge6", 32'(btn_press[0]), 32'd1);
    check("clean_level_edge6", 32'(btn_level[0]), 32'd1);
    for (int k = 7; k <= 20; k++) tick(k);
    check("clean_first_edge", 32'(first_press[0]), 32'd6);
`ifdef BTN_AUTOREPEAT_EN
    check("clean_press_count", 32'(press_cnt[0]), 32'd3);   // edges 6, 16, 19
`else
    check("clean_press_count", 32'(press_cnt[0]), 32'd1);
`endif
    check("clean_no_release", 32'(release_cnt[0]), 32'd0);
    check("clean_ch1_quiet",  32'(press_cnt[1]), 32'd0);

    // ---- Release glitch of 2 cycles, then a real release ----
    clear_stats();
    lvl_min = 2'b11;
    btn_n = 2'b11;
    tick(1);
    tick(2);
    btn_n = 2'b10;
    for (int k = 3; k <= 12; k++) begin
      tick(k);
      lvl_min = lvl_min & btn_level;
    end
    check("glitch_no_release", 32'(release_cnt[0]), 32'd0);
    check("glitch_level_held", 32'(lvl_min[0]), 32'd1);
    btn_n = 2'b11;
    clear_stats();
    for (int k = 1; k <= 5; k++) tick(k);
    check("rel_level_edge5", 32'(btn_level[0]), 32'd1);
    tick(6);
    check("rel_pulse_edge6", 32'(btn_release[0]), 32'd1);
    check("rel_level_edge6", 32'(btn_level[0]), 32'd0);
    tick(7);
    check("rel_pulse_len1", 32'(btn_release[0]), 32'd0);

    // ---- Bounce: low 3, high 1, low 2, high 1, then low held ----
    clear_stats();
    e = 0;
    btn_n = 2'b10; repeat (3) begin e++; tick(e); end
    btn_n = 2'b11; e++; tick(e);
    btn_n = 2'b10; repeat (2) begin e++; tick(e); end
    btn_n = 2'b11; e++; tick(e);
    btn_n = 2'b10;
    while (e < 19) begin e++; tick(e); end
    check("bounce_first_edge", 32'(first_press[0]), 32'd13);
    check("bounce_press_count", 32'(press_cnt[0]), 32'd1);
    btn_n = 2'b11;
    for (int k = 1; k <= 10; k++) tick(k);

    // ---- Simultaneous press and release on both channels ----
    btn_n = 2'b00;
    clear_stats();
    for (int k = 1; k <= 5; k++) tick(k);
    check("sim_press_edge5", 32'(btn_press), 32'b00);
    tick(6);
    check("sim_press_edge6", 32'(btn_press), 32'b11);
    tick(7);
    check("sim_press_len1", 32'(btn_press), 32'b00);
    btn_n = 2'b11;
    clear_stats();
    for (int k = 1; k <= 6; k++) tick(k);
    check("sim_release_edge6", 32'(btn_release), 32'b11);
    check("sim_level_cleared", 32'(btn_level), 32'b00);
    for (int k = 7; k <= 10; k++) tick(k);

    // ---- Auto-repeat: hold channel 0 for 30 cycles ----
    btn_n = 2'b10;
    clear_stats();
    for (int k = 1; k <= 30; k++) tick(k);
`ifdef BTN_AUTOREPEAT_EN
    exp_edges = '{6, 16, 19, 22, 25, 28};
`else
    exp_edges = '{6};
`endif
    check("rpt_count", 32'(press_edges.size()), 32'(exp_edges.size()));
    for (int k = 0; k < exp_edges.size(); k++) begin
      if (k < press_edges.size())
        check($sformatf("rpt_edge%0d", k), 32'(press_edges[k]), 32'(exp_edges[k]));
    end

    // ---- Reset mid-operation while held ----
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_level_async", 32'(btn_level), 32'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    for (int k = 1; k <= 8; k++) tick(k);
    check("midrst_repress_edge", 32'(first_press[0]), 32'd6);

    check("no_press_release_overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
